// File: rtl/vga_pattern_seq.sv
// Test-pattern sequencer for a 640x480 VGA pipeline: selects SOLID/BARS/CHECKER/GRAD,
// switching only at frame boundaries on a button request or after a timed rotation.
module vga_pattern_seq #(
  parameter int unsigned FRAMES_PER_PATTERN = 60,
  parameter int unsigned SYNC_STAGES        = 2
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic        vsync,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [11:0] sw,
  input  logic        mode_btn,
  input  logic        auto_en,
  output logic [11:0] rgb,
  output logic [1:0]  pattern
);

  localparam int unsigned CW = $clog2(FRAMES_PER_PATTERN);

  typedef enum logic [1:0] {
    SOLID   = 2'd0,
    BARS    = 2'd1,
    CHECKER = 2'd2,
    GRAD    = 2'd3
  } pat_t;

  pat_t                 state, state_n;
  logic [SYNC_STAGES-1:0] btn_sync, auto_sync;
  logic [SYNC_STAGES:0]   prime;
  logic                 btn_prev, vsync_q;
  logic                 pending, pending_n;
  logic [CW-1:0]        frame_cnt, frame_cnt_n;
  logic                 btn_s, auto_s, btn_pulse, frame_edge, expire, advance;
  logic [11:0]          colour;
  logic [2:0]           bar;
  logic                 unused_bits;

  assign unused_bits = ^{y[9], y[4:0]};

  // prime is one stage longer than the synchronizer so a button already held
  // through reset has reached btn_prev before edges are accepted
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync  <= '0;
      auto_sync <= '0;
      prime     <= '0;
      btn_prev  <= 1'b0;
      vsync_q   <= 1'b0;
    end else begin
      btn_sync[0]  <= mode_btn;
      auto_sync[0] <= auto_en;
      prime[0]     <= 1'b1;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        btn_sync[i]  <= btn_sync[i-1];
        auto_sync[i] <= auto_sync[i-1];
      end
      for (int unsigned i = 1; i <= SYNC_STAGES; i++) begin
        prime[i] <= prime[i-1];
      end
      btn_prev <= btn_s;
      vsync_q  <= vsync;
    end
  end

  assign btn_s      = btn_sync[SYNC_STAGES-1];
  assign auto_s     = auto_sync[SYNC_STAGES-1];
  assign btn_pulse  = prime[SYNC_STAGES] & btn_s & ~btn_prev;
  assign frame_edge = vsync_q & ~vsync;
  assign expire     = auto_s && (frame_cnt == CW'(FRAMES_PER_PATTERN - 1));
  assign advance    = frame_edge & (pending | expire);

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SOLID;
      pending   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      frame_cnt <= frame_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    pending_n   = pending;
    frame_cnt_n = frame_cnt;

    // a press landing on a boundary is kept only if no request was already being served
    if (frame_edge) pending_n = ~pending & btn_pulse;
    else            pending_n = pending | btn_pulse;

    if (advance) begin
      case (state)
        SOLID:   state_n = BARS;
        BARS:    state_n = CHECKER;
        CHECKER: state_n = GRAD;
        GRAD:    state_n = SOLID;
        default: state_n = SOLID;
      endcase
    end

    if (!auto_s || advance) frame_cnt_n = '0;
    else if (frame_edge)    frame_cnt_n = CW'(frame_cnt + 1'b1);
  end

  always_comb begin
    bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (x >= 10'(80 * k)) bar = 3'(k);
    end
  end

  always_comb begin
    colour = '0;
    case (state)
      SOLID: colour = sw;
      BARS: begin
        case (bar)
          3'd0:    colour = 12'hFFF;
          3'd1:    colour = 12'hFF0;
          3'd2:    colour = 12'h0FF;
          3'd3:    colour = 12'h0F0;
          3'd4:    colour = 12'hF0F;
          3'd5:    colour = 12'hF00;
          3'd6:    colour = 12'h00F;
          default: colour = 12'h000;
        endcase
      end
      CHECKER: colour = (x[5] ^ y[5]) ? 12'hFFF : 12'h000;
      GRAD:    colour = {x[9:6], y[8:5], sw[3:0]};
      default: colour = '0;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n)    rgb <= '0;
    else if (p_tick) rgb <= video_on ? colour : 12'h000;
  end

  assign pattern = state;

endmodule

// File: tb/tb_vga_pattern_seq.sv
// Bench for vga_pattern_seq: directed scenarios plus randomized frames, checked every
// cycle against a frame-level behavioural model of the pattern sequencer.
module tb_vga_pattern_seq;

  localparam int FPP = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p_tick = 1'b0, video_on = 1'b0, vsync = 1'b1;
  logic [9:0]  x = '0, y = '0;
  logic [11:0] sw = '0;
  logic        mode_btn = 1'b0, auto_en = 1'b0;
  logic [11:0] rgb;
  logic [1:0]  pattern;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit rnd_on   = 1'b0;

  vga_pattern_seq #(.FRAMES_PER_PATTERN(FPP), .SYNC_STAGES(2)) dut (
    .clk_100MHz(clk), .reset_n(reset_n), .p_tick(p_tick), .video_on(video_on),
    .vsync(vsync), .x(x), .y(y), .sw(sw), .mode_btn(mode_btn), .auto_en(auto_en),
    .rgb(rgb), .pattern(pattern)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] colour(int p, logic [9:0] xx, logic [9:0] yy, logic [11:0] s);
    logic [11:0] pal [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    int k;
    logic [3:0] gx, gy;
    case (p)
      0: return s;
      1: begin
        k = int'(xx) / 80;
        if (k > 7) k = 7;
        return pal[k];
      end
      2: return (((int'(xx) / 32) % 2) != ((int'(yy) / 32) % 2)) ? 12'hFFF : 12'h000;
      default: begin
        gx = 4'(int'(xx) / 64);
        gy = 4'((int'(yy) / 32) % 16);
        return {gx, gy, s[3:0]};
      end
    endcase
  endfunction

  // Frame-level model: a press queues one request, a vsync fall serves it or the timer
  int          m_pattern = 0, m_cnt = 0;
  bit          m_pending = 1'b0, m_vs_prev = 1'b0, m_btn_prev = 1'b0;
  logic [11:0] m_rgb = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pattern  <= 0;
      m_cnt      <= 0;
      m_pending  <= 1'b0;
      m_rgb      <= '0;
      m_vs_prev  <= 1'b0;
      m_btn_prev <= mode_btn;
    end else begin : model_step
      bit fb;
      int np, nc;
      bit npend;
      fb    = m_vs_prev && !vsync;
      np    = m_pattern;
      nc    = m_cnt;
      npend = m_pending;
      if (p_tick) m_rgb <= video_on ? colour(m_pattern, x, y, sw) : 12'h000;
      if (fb) begin
        if (m_pending || (auto_en && m_cnt == FPP - 1)) begin
          np = (m_pattern + 1) % 4;
          nc = 0;
        end else begin
          nc = m_cnt + 1;
        end
        npend = 1'b0;
      end
      if (!auto_en) nc = 0;
      if (mode_btn && !m_btn_prev) npend = 1'b1;
      m_pattern  <= np;
      m_cnt      <= nc;
      m_pending  <= npend;
      m_vs_prev  <= vsync;
      m_btn_prev <= mode_btn;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (rgb !== m_rgb) begin
        n_fail++;
        $display("FAIL cycle_rgb t=%0t got %h expected %h", $time, rgb, m_rgb);
      end
      n_checks++;
      if (pattern !== 2'(m_pattern)) begin
        n_fail++;
        $display("FAIL cycle_pattern t=%0t got %0d expected %0d", $time, pattern, m_pattern);
      end
    end
  end

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic run_cycles(int n);
    repeat (n) begin
      cyc();
      if (rnd_on) begin
        x        = 10'($urandom_range(0, 799));
        y        = 10'($urandom_range(0, 524));
        video_on = 1'($urandom_range(0, 1));
        p_tick   = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  task automatic boundary();
    vsync = 1'b0;
    run_cycles(4);
    vsync = 1'b1;
    run_cycles(20);
  endtask

  task automatic press();
    mode_btn = 1'b1;
    run_cycles(8);
    mode_btn = 1'b0;
    run_cycles(8);
  endtask

  task automatic pix(logic [9:0] xx, logic [9:0] yy);
    x = xx; y = yy; video_on = 1'b1; p_tick = 1'b1;
    cyc();
    p_tick = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    check("reset_rgb", rgb, 12'h000);
    check("reset_pattern", 12'(pattern), 12'h0);
    chk_en  = 1'b1;
    reset_n = 1'b1;
    run_cycles(5);

    sw = 12'hA5C;
    pix(10'd100, 10'd100);
    check("solid_rgb", rgb, 12'hA5C);
    video_on = 1'b0; p_tick = 1'b1;
    cyc();
    p_tick = 1'b0;
    check("blank_rgb", rgb, 12'h000);

    press();
    run_cycles(10);
    check("pending_hold", 12'(pattern), 12'h0);
    boundary();
    check("btn_advance", 12'(pattern), 12'h1);
    pix(10'd85, 10'd0);
    check("bars_x85", rgb, 12'hFF0);
    pix(10'd639, 10'd0);
    check("bars_x639", rgb, 12'h000);
    video_on = 1'b0;
    pix(10'd79, 10'd200);
    check("bars_x79", rgb, 12'hFFF);

    press(); boundary();
    check("to_checker", 12'(pattern), 12'h2);
    pix(10'd32, 10'd0);
    check("checker_32_0", rgb, 12'hFFF);
    pix(10'd32, 10'd32);
    check("checker_32_32", rgb, 12'h000);
    press(); boundary();
    check("to_grad", 12'(pattern), 12'h3);
    sw = 12'h007;
    pix(10'd639, 10'd479);
    check("grad_corner", rgb, 12'h9E7);
    video_on = 1'b0; p_tick = 1'b1;
    cyc();
    p_tick = 1'b0;
    check("grad_blank", rgb, 12'h000);

    // button held across reset must not count as a press
    mode_btn = 1'b1;
    reset_n  = 1'b0;
    run_cycles(3);
    reset_n = 1'b1;
    run_cycles(10);
    mode_btn = 1'b0;
    run_cycles(5);
    boundary();
    check("held_btn_no_edge", 12'(pattern), 12'h0);

    auto_en = 1'b1;
    run_cycles(5);
    for (int b = 1; b <= 12; b++) begin
      boundary();
      check($sformatf("auto_b%0d", b), 12'(pattern), 12'((b / 3) % 4));
    end

    boundary();
    press(); boundary();
    check("btn_mid_count", 12'(pattern), 12'h1);
    boundary(); boundary();
    check("btn_cleared_count", 12'(pattern), 12'h1);
    press(); press(); boundary();
    check("coincide_once", 12'(pattern), 12'h2);
    boundary(); boundary();
    check("coincide_wrap_hold", 12'(pattern), 12'h2);
    boundary();
    check("coincide_wrap_adv", 12'(pattern), 12'h3);

    boundary(); boundary();
    pix(10'd639, 10'd479);
    press();
    auto_en = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_rgb", rgb, 12'h000);
    check("async_rst_pattern", 12'(pattern), 12'h0);
    run_cycles(3);
    reset_n = 1'b1;
    run_cycles(10);
    boundary(); boundary(); boundary();
    check("rst_discard", 12'(pattern), 12'h0);

    rnd_on = 1'b1;
    for (int f = 0; f < 200; f++) begin
      sw = 12'($urandom);
      run_cycles(3);
      if ($urandom_range(0, 3) == 0) auto_en = ~auto_en;
      run_cycles(3);
      if ($urandom_range(0, 2) == 0) begin
        press();
        if ($urandom_range(0, 1) == 0) press();
      end
      run_cycles(6);
      boundary();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_seq.md
VGA_PATTERN_SEQ -- requirements
Module: vga_pattern_seq

Interface
REQ-001 SHALL have parameter FRAMES_PER_PATTERN, default 60: frames each pattern is shown in auto mode (range 2..1023).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for asynchronous inputs.
REQ-003 SHALL have port clk_100MHz  input  1: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port p_tick  input  1: pixel-enable strobe from the VGA controller, one clk_100MHz cycle wide.
REQ-006 SHALL have port video_on  input  1: high inside the 640x480 display area.
REQ-007 SHALL have port vsync  input  1: controller vertical sync, active low.
REQ-008 SHALL have port x  input  10: current pixel column, 0..639 when video_on.
REQ-009 SHALL have port y  input  10: current pixel row, 0..479 when video_on.
REQ-010 SHALL have port sw  input  12: user colour, {R[11:8],G[7:4],B[3:0]}.
REQ-011 SHALL have port mode_btn  input  1: asynchronous pushbutton requesting next pattern.
REQ-012 SHALL have port auto_en  input  1: asynchronous switch enabling timed pattern rotation.
REQ-013 SHALL have port rgb  output  12: registered pixel colour to the DAC pins.
REQ-014 SHALL have port pattern  output  2: current pattern state encoding.

Function
REQ-015 SHALL pass mode_btn and auto_en through SYNC_STAGES flops each; mode_btn SHALL be rising-edge detected after synchronization into a 1-cycle pulse.
REQ-016 SHALL keep a 4-state FSM: SOLID(0) -> BARS(1) -> CHECKER(2) -> GRAD(3) -> SOLID(0), advancing one step per advance event, never skipping.
REQ-017 SHALL detect a frame boundary as a vsync 1->0 transition (vsync registered once, compared with current value).
REQ-018 SHALL set a pending flag on a mode_btn pulse; pattern SHALL change only at the next frame boundary, then pending clears.
REQ-019 SHALL count frame boundaries in a frame counter while synchronized auto_en=1; on the boundary where counter = FRAMES_PER_PATTERN-1, counter SHALL wrap to 0 and the pattern SHALL advance.
REQ-020 SHALL hold the frame counter at 0 while synchronized auto_en=0.
REQ-021 SHALL advance exactly once when a pending button request and auto expiry coincide on the same frame boundary; counter still wraps to 0.
REQ-022 SHALL ignore further mode_btn pulses while pending is set (max one advance per frame from the button).
REQ-023 SHALL clear the frame counter to 0 on any button-caused advance.
REQ-024 SHALL compute pixel colour combinationally per pattern: SOLID = sw; BARS = bar index k = count of thresholds {80,160,...,560} that x >= , colours k0..k7 = FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000; CHECKER = (x[5]^y[5]) ? FFF : 000; GRAD = {x[9:6], y[8:5], sw[3:0]}.
REQ-025 SHALL register rgb only on cycles with p_tick=1: rgb <= video_on ? colour : 12'h000; rgb holds otherwise; latency one p_tick.
REQ-026 SHALL force rgb to 12'h000 when the registered sample had video_on=0 (blanking), in every pattern.
REQ-027 SHALL use pattern (the FSM state) for colour selection in the same cycle the FSM updates; no partial-frame mixing since changes occur only in vertical blanking.

Reset
REQ-028 SHALL, while reset_n=0, immediately force rgb=000, pattern=SOLID, pending=0, frame counter=0, all synchronizer and edge-detect flops=0.
REQ-029 SHALL discard a pending request and partial frame count when reset asserts mid-operation; after release, first advance requires a new event.
REQ-030 SHALL, after reset release, treat a synchronized mode_btn already high as no edge (no spurious advance).

Verification
REQ-031 Reset then sw=12'hA5C, SOLID, video_on=1, p_tick pulse -> next cycle rgb=A5C; with video_on=0 -> rgb=000.
REQ-032 mode_btn pulse mid-frame -> pattern stays 0 until next vsync falling edge, then 1; BARS at x=85 -> rgb=FF0, x=639 -> 000.
REQ-033 FRAMES_PER_PATTERN=3, auto_en=1, no button -> pattern advances on 3rd, 6th, 9th, 12th boundary: 1,2,3,0.
REQ-034 Button pending plus auto expiry on same boundary -> pattern advances by exactly 1, counter=0; second press same frame -> ignored.
REQ-035 CHECKER at (x=32,y=0) -> FFF, (32,32) -> 000; GRAD at (x=639,y=479,sw[3:0]=7) -> rgb=9E7.
REQ-036 reset_n low with pending=1 and counter=2 -> rgb=000 asynchronously, pattern=0; after release, vsync edge alone causes no advance (auto_en=0).
